// File: rtl/mat_seq_mult.sv
// Sequential N x N matrix multiplier (Res = A*B), N MAC lanes, one per output column.
// Latency: N*N cycles from operand acceptance to out_valid; one transaction in flight.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
module mat_seq_mult #(
    parameter int WIDTH = 8,
    parameter int N = 2,
    localparam int ACC_W = 2*WIDTH + $clog2(N)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   signed_en,
    input  logic [N*N*WIDTH-1:0]   A,
    input  logic [N*N*WIDTH-1:0]   B,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [N*N*ACC_W-1:0]   Res
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int NN = N*N;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t                 state, state_nxt;
    logic [NN*WIDTH-1:0]    a_q, b_q;
    logic                   sgn_q;
    logic [CW-1:0]          i_q, k_q;
    logic [ACC_W-1:0]       acc_q [N];
    logic [ACC_W-1:0]       sum   [N];
    logic [NN*ACC_W-1:0]    res_q;
    logic                   last_k, last_row;

    // Extension to ACC_W keeps the product exact modulo 2^ACC_W in both modes.
    function automatic logic [ACC_W-1:0] ext(input logic [WIDTH-1:0] v, input logic s);
        return s ? {{(ACC_W-WIDTH){v[WIDTH-1]}}, v} : {{(ACC_W-WIDTH){1'b0}}, v};
    endfunction

    assign last_k   = (k_q == CW'(N-1));
    assign last_row = (i_q == CW'(N-1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = COMPUTE;
            COMPUTE: if (last_k && last_row) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Lane j consumes A[i][k] (shared by all lanes) and B[k][j].
    always_comb begin
        for (int j = 0; j < N; j++) begin
            sum[j] = acc_q[j]
                   + ext(a_q[(NN-1-(int'(i_q)*N+int'(k_q)))*WIDTH +: WIDTH], sgn_q)
                   * ext(b_q[(NN-1-(int'(k_q)*N+j))*WIDTH +: WIDTH], sgn_q);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q   <= '0;
            b_q   <= '0;
            sgn_q <= 1'b0;
            i_q   <= '0;
            k_q   <= '0;
            res_q <= '0;
            for (int j = 0; j < N; j++) acc_q[j] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= A;
                        b_q   <= B;
                        sgn_q <= signed_en;
                        i_q   <= '0;
                        k_q   <= '0;
                        for (int j = 0; j < N; j++) acc_q[j] <= '0;
                    end
                end
                COMPUTE: begin
                    if (last_k) begin
                        // Row i complete: retire each lane's sum into Res row i.
                        for (int j = 0; j < N; j++) begin
                            res_q[(NN-1-(int'(i_q)*N+j))*ACC_W +: ACC_W] <= sum[j];
                            acc_q[j] <= '0;
                        end
                        k_q <= '0;
                        i_q <= last_row ? '0 : i_q + CW'(1);
                    end else begin
                        for (int j = 0; j < N; j++) acc_q[j] <= sum[j];
                        k_q <= k_q + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign Res       = res_q;

endmodule

// File: tb/tb_mat_seq_mult.sv
// Bench for mat_seq_mult: directed N=2 cases plus randomized N=4 traffic against a matrix model.
module tb_mat_seq_mult;

    localparam int W    = 8;
    localparam int ACC2 = 2*W + 1;
    localparam int ACC4 = 2*W + 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic                v2, r2, s2, ov2, or2;
    logic [31:0]         a2, b2;
    logic [4*ACC2-1:0]   res2;

    logic                v4, r4, s4, ov4, or4;
    logic [127:0]        a4, b4;
    logic [16*ACC4-1:0]  res4;

    int checks = 0;
    int passed = 0;

    mat_seq_mult #(.WIDTH(W), .N(2)) u_dut2 (
        .clk(clk), .reset(reset), .in_valid(v2), .in_ready(r2), .signed_en(s2),
        .A(a2), .B(b2), .out_valid(ov2), .out_ready(or2), .Res(res2)
    );

    mat_seq_mult #(.WIDTH(W), .N(4)) u_dut4 (
        .clk(clk), .reset(reset), .in_valid(v4), .in_ready(r4), .signed_en(s4),
        .A(a4), .B(b4), .out_valid(ov4), .out_ready(or4), .Res(res4)
    );

    // Reference: textbook row-by-column dot products in 64-bit arithmetic, truncated to ACC_W.
    function automatic longint elem(input logic [127:0] m, input int n, input int r, input int c, input bit s);
        logic [7:0] e;
        e = m[(n*n-1-(r*n+c))*8 +: 8];
        return s ? longint'($signed(e)) : longint'(e);
    endfunction

    function automatic logic [511:0] model(input logic [127:0] a, input logic [127:0] b, input int n, input bit s);
        logic [511:0] r;
        logic [63:0]  sv;
        longint       sum;
        int           accw;
        r = '0;
        accw = 2*W + $clog2(n);
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < n; j++) begin
                sum = 0;
                for (int k = 0; k < n; k++) sum += elem(a, n, i, k, s) * elem(b, n, k, j, s);
                sv = sum;
                for (int t = 0; t < accw; t++) r[(n*n-1-(i*n+j))*accw + t] = sv[t];
            end
        end
        return r;
    endfunction

    task automatic send2(input logic [31:0] a, input logic [31:0] b, input logic s);
        int guard = 0;
        @(negedge clk);
        while (!r2 && guard < 50) begin @(negedge clk); guard++; end
        if (guard >= 50) begin
            checks++;
            $display("FAIL send2_timeout in_ready=%0b required=1", r2);
        end
        a2 = a; b2 = b; s2 = s; v2 = 1'b1;
        @(posedge clk); #1;
        v2 = 1'b0; a2 = $urandom; b2 = $urandom; s2 = ~s;
    endtask

    task automatic wait_out2(output int lat, output bit rdy_low);
        lat = 0; rdy_low = 1'b1;
        do begin
            @(posedge clk); lat++;
            @(negedge clk);
            if (r2) rdy_low = 1'b0;
        end while (!ov2 && lat < 100);
    endtask

    task automatic consume2();
        or2 = 1'b1;
        @(posedge clk); #1;
        or2 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        #2;
        checks++; if (r2 !== 1'b1) $display("FAIL reset_in_ready got=%0b exp=1", r2); else passed++;
        checks++; if (ov2 !== 1'b0) $display("FAIL reset_out_valid got=%0b exp=0", ov2); else passed++;
        checks++; if (res2 !== '0) $display("FAIL reset_res got=%h exp=0", res2); else passed++;
        checks++; if (ov4 !== 1'b0 || r4 !== 1'b1) $display("FAIL reset_n4 ov=%0b rdy=%0b exp=0/1", ov4, r4); else passed++;
        @(negedge clk); reset = 1'b1;
    endtask

    task automatic run_directed(input string name, input logic [31:0] a, input logic [31:0] b,
                                input logic s, input logic [4*ACC2-1:0] exp);
        int lat; bit rl;
        send2(a, b, s);
        wait_out2(lat, rl);
        checks++; if (lat !== 4) $display("FAIL %s_latency got=%0d exp=4", name, lat); else passed++;
        checks++; if (!rl) $display("FAIL %s_in_ready_low got=1 exp=0", name); else passed++;
        checks++; if (res2 !== exp) $display("FAIL %s_res got=%h exp=%h", name, res2, exp); else passed++;
        consume2();
        checks++; if (ov2 !== 1'b0 || r2 !== 1'b1) $display("FAIL %s_consume ov=%0b rdy=%0b exp=0/1", name, ov2, r2); else passed++;
    endtask

    task automatic test_directed();
        run_directed("unsigned", {8'd1, 8'd2, 8'd3, 8'd4}, {8'd5, 8'd6, 8'd7, 8'd8}, 1'b0,
                     {17'd19, 17'd22, 17'd43, 17'd50});
        run_directed("signed", {8'hFF, 8'h02, 8'h03, 8'hFC}, {8'd1, 8'd0, 8'd0, 8'd1}, 1'b1,
                     {17'h1FFFF, 17'd2, 17'd3, 17'h1FFFC});
        run_directed("signed_off", {8'hFF, 8'h02, 8'h03, 8'hFC}, {8'd1, 8'd0, 8'd0, 8'd1}, 1'b0,
                     {17'd255, 17'd2, 17'd3, 17'd252});
        run_directed("max_unsigned", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, {4{17'd130050}});
    endtask

    task automatic test_backpressure();
        logic [31:0] a, b; logic s; logic [511:0] exp, got; int lat; bit rl; int bad = 0;
        a = $urandom; b = $urandom; s = 1'b1;
        exp = model({96'd0, a}, {96'd0, b}, 2, s);
        send2(a, b, s);
        wait_out2(lat, rl);
        for (int c = 0; c < 10; c++) begin
            v2 = c[0]; a2 = $urandom; b2 = $urandom;
            @(negedge clk);
            got = '0; got[4*ACC2-1:0] = res2;
            if (ov2 !== 1'b1 || got !== exp || r2 !== 1'b0) bad++;
        end
        v2 = 1'b0;
        checks++; if (bad != 0) $display("FAIL hold_stable bad_cycles=%0d exp=0", bad); else passed++;
        consume2();
        checks++; if (r2 !== 1'b1 || ov2 !== 1'b0) $display("FAIL hold_release rdy=%0b ov=%0b exp=1/0", r2, ov2); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b; logic s; logic [511:0] exp, got; int lat; bit rl;
        for (int t = 0; t < 2; t++) begin
            a = $urandom; b = $urandom; s = t[0];
            exp = model({96'd0, a}, {96'd0, b}, 2, s);
            send2(a, b, s);
            wait_out2(lat, rl);
            got = '0; got[4*ACC2-1:0] = res2;
            checks++; if (lat !== 4) $display("FAIL b2b_latency got=%0d exp=4", lat); else passed++;
            checks++; if (got !== exp) $display("FAIL b2b_res got=%h exp=%h", got, exp); else passed++;
            consume2();
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] a, b; logic [511:0] exp, got; int lat; bit rl; int bad = 0;
        send2(32'h0102_0304, 32'h0506_0708, 1'b0);
        @(posedge clk); @(posedge clk); #2;
        reset = 1'b0;
        #1;
        checks++; if (ov2 !== 1'b0) $display("FAIL midrst_out_valid got=%0b exp=0", ov2); else passed++;
        checks++; if (r2 !== 1'b1) $display("FAIL midrst_in_ready got=%0b exp=1", r2); else passed++;
        checks++; if (res2 !== '0) $display("FAIL midrst_res got=%h exp=0", res2); else passed++;
        @(negedge clk); reset = 1'b1;
        repeat (6) begin @(negedge clk); if (ov2 !== 1'b0) bad++; end
        checks++; if (bad != 0) $display("FAIL midrst_no_output bad=%0d exp=0", bad); else passed++;
        a = $urandom; b = $urandom;
        exp = model({96'd0, a}, {96'd0, b}, 2, 1'b1);
        send2(a, b, 1'b1);
        wait_out2(lat, rl);
        got = '0; got[4*ACC2-1:0] = res2;
        checks++; if (got !== exp) $display("FAIL midrst_fresh_res got=%h exp=%h", got, exp); else passed++;
        consume2();
    endtask

    task automatic test_n4_random();
        logic [127:0] a, b; bit s; logic [511:0] exp, got; int lat; int guard;
        for (int t = 0; t < 200; t++) begin
            a = {$urandom, $urandom, $urandom, $urandom};
            b = {$urandom, $urandom, $urandom, $urandom};
            s = 1'($urandom_range(0, 1));
            exp = model(a, b, 4, s);
            @(negedge clk);
            guard = 0;
            while (!r4 && guard < 50) begin @(negedge clk); guard++; end
            a4 = a; b4 = b; s4 = s; v4 = 1'b1;
            @(posedge clk); #1;
            v4 = 1'b0; a4 = ~a; b4 = ~b; s4 = ~s;
            lat = 0;
            do begin
                @(posedge clk); lat++;
                @(negedge clk);
                or4 = ov4 ? 1'b0 : 1'($urandom_range(0, 1));
            end while (!ov4 && lat < 100);
            got = '0; got[16*ACC4-1:0] = res4;
            checks++; if (lat !== 16) $display("FAIL n4_latency t=%0d got=%0d exp=16", t, lat); else passed++;
            checks++; if (got !== exp) $display("FAIL n4_res t=%0d s=%0b got=%h exp=%h", t, s, got, exp); else passed++;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            or4 = 1'b1;
            @(posedge clk); #1;
            or4 = 1'b0;
        end
        @(negedge clk);
        checks++; if (ov4 !== 1'b0 || r4 !== 1'b1) $display("FAIL n4_final ov=%0b rdy=%0b exp=0/1", ov4, r4); else passed++;
    endtask

    initial begin
        v2 = 1'b0; s2 = 1'b0; or2 = 1'b0; a2 = '0; b2 = '0;
        v4 = 1'b0; s4 = 1'b0; or4 = 1'b0; a4 = '0; b4 = '0;
        test_reset();
        test_directed();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_n4_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
